// File: rtl/noise_pkg.sv
// -----------------------------------------------------------------------------
// noise_pkg
//   Shared constants for the multi-channel noise generator.
//   - LVL_*  : per-channel 2-bit amplitude level codes (off, /8, /4, /2)
//   - MODE_* : per-channel output mode (white or smoothed)
//   - TAPS_16 / SEED_16 : default 16-bit Fibonacci tap mask and base seed
// -----------------------------------------------------------------------------
package noise_pkg;

  localparam logic [1:0] LVL_OFF = 2'b00;
  localparam logic [1:0] LVL_LO  = 2'b01;
  localparam logic [1:0] LVL_MED = 2'b10;
  localparam logic [1:0] LVL_HI  = 2'b11;

  localparam logic MODE_WHITE  = 1'b0;
  localparam logic MODE_SMOOTH = 1'b1;

  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;

endpackage : noise_pkg

// File: rtl/noise_lfsr_ch.sv
// -----------------------------------------------------------------------------
// noise_lfsr_ch
//   One noise channel: Fibonacci LFSR with runtime seed load, amplitude
//   scaling by level, and a first-order smoother (y += (x - y) / 4).
//   The sample output is combinational and reflects the state this channel
//   will hold after the coming tick, so the top can register it on the tick.
// Ports
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   tick_i         in   advance LFSR and smoother this cycle
//   seed_load_i    in   load seed_value_i into the LFSR, clear the smoother
//   seed_value_i   in   WIDTH  seed (0 is replaced by SEED)
//   mode_i         in   0 = white, 1 = smoothed
//   level_i        in   2-bit amplitude level
//   sample_o       out  WIDTH  sample produced by the coming tick
// -----------------------------------------------------------------------------
module noise_lfsr_ch
  import noise_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_16),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(SEED_16)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_value_i,
  input  logic             mode_i,
  input  logic [1:0]       level_i,
  output logic [WIDTH-1:0] sample_o
);

  logic [WIDTH-1:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [WIDTH-1:0]        lfsr_step;
  logic [WIDTH-1:0]        x;
  logic [WIDTH-1:0]        y_step;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   diff_sh;

  always_comb begin
    lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    // Top bit forced to zero so the scaled sample is always non-negative.
    case (level_i)
      LVL_LO:  x = {1'b0, lfsr_step[WIDTH-2:0]} >> 3;
      LVL_MED: x = {1'b0, lfsr_step[WIDTH-2:0]} >> 2;
      LVL_HI:  x = {1'b0, lfsr_step[WIDTH-2:0]} >> 1;
      default: x = '0;
    endcase

    // Difference needs one extra bit to stay signed; arithmetic shift floors.
    diff    = $signed({1'b0, x}) - $signed({1'b0, y_q});
    diff_sh = diff >>> 2;
    y_step  = y_q + diff_sh[WIDTH-1:0];

    sample_o = (mode_i == MODE_WHITE) ? x : y_step;

    // The smoother tracks in white mode too, so a mode switch is seamless.
    lfsr_d = lfsr_q;
    y_d    = y_q;
    if (seed_load_i) begin
      lfsr_d = (seed_value_i == '0) ? SEED : seed_value_i;
      y_d    = '0;
    end else if (tick_i) begin
      lfsr_d = lfsr_step;
      y_d    = y_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= INIT;
      y_q    <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      y_q    <= y_d;
    end
  end

endmodule : noise_lfsr_ch

// File: rtl/noise_generator_mc.sv
// -----------------------------------------------------------------------------
// noise_generator_mc
//   Multi-channel LFSR noise source feeding the mixer. NUM_CH independent
//   channels share one programmable rate divider; every tick produces one
//   frame presented on a valid/ready output register with a sticky overrun.
//
//   Handshake: a frame transfers on any clk edge where noise_valid and
//   noise_ready are both 1. noise_valid never drops and noise_data never
//   changes while noise_valid=1 and noise_ready=0; a tick in that state
//   drops its frame and sets overrun.
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enable       in   divider runs and LFSRs advance
//   rate_div     in   DIV_W        update period minus one
//   mode         in   NUM_CH       per channel 0 = white, 1 = smoothed
//   noise_level  in   2*NUM_CH     per channel level (00 off .. 11 /2)
//   seed_load    in   load seed_value into channel seed_ch
//   seed_ch      in   CH_W         seed target channel
//   seed_value   in   WIDTH        seed (0 replaced by SEED)
//   noise_valid  out  frame available
//   noise_ready  in   consumer accepts frame
//   noise_data   out  WIDTH*NUM_CH channel c at [c*WIDTH +: WIDTH]
//   overrun      out  sticky dropped-frame flag
//   overrun_clr  in   clears overrun (a same-cycle overrun wins)
// -----------------------------------------------------------------------------
module noise_generator_mc
  import noise_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter int               NUM_CH = 4,
  parameter int               DIV_W  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(SEED_16),
  localparam int              CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        rate_div,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [2*NUM_CH-1:0]     noise_level,
  input  logic                    seed_load,
  input  logic [CH_W-1:0]         seed_ch,
  input  logic [WIDTH-1:0]        seed_value,
  output logic                    noise_valid,
  input  logic                    noise_ready,
  output logic [WIDTH*NUM_CH-1:0] noise_data,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  logic [DIV_W-1:0]        count_q, count_d;
  logic                    tick;
  logic [WIDTH*NUM_CH-1:0] frame;
  logic                    valid_q, valid_d;
  logic [WIDTH*NUM_CH-1:0] data_q, data_d;
  logic                    ovr_q, ovr_d;
  logic                    ovr_evt;

  // ---------------------------------------------------------------------------
  // Rate divider. Equality compare only: if rate_div drops below the count,
  // the counter runs on through its wrap before the next tick.
  // ---------------------------------------------------------------------------
  assign tick = enable && (count_q == rate_div);

  always_comb begin
    count_d = count_q;
    if (!enable)  count_d = '0;
    else if (tick) count_d = '0;
    else           count_d = count_q + DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Channels. Channel c resets to SEED rotated left by c so channels differ.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int               ROT  = c % WIDTH;
    localparam logic [WIDTH-1:0] INIT = (SEED << ROT) | (SEED >> ((WIDTH - ROT) % WIDTH));

    logic seed_hit;
    // Out-of-range seed_ch values match no channel and are ignored.
    assign seed_hit = seed_load && (seed_ch == CH_W'(c));

    noise_lfsr_ch #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED),
      .INIT  (INIT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick),
      .seed_load_i  (seed_hit),
      .seed_value_i (seed_value),
      .mode_i       (mode[c]),
      .level_i      (noise_level[2*c +: 2]),
      .sample_o     (frame[c*WIDTH +: WIDTH])
    );
  end

  // ---------------------------------------------------------------------------
  // Output register, handshake and overrun.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    ovr_evt = 1'b0;

    if (tick) begin
      if (!valid_q || noise_ready) begin
        data_d  = frame;
        valid_d = 1'b1;
      end else begin
        // Held frame stays put; this tick's frame is lost.
        ovr_evt = 1'b1;
      end
    end else if (valid_q && noise_ready) begin
      valid_d = 1'b0;
    end

    if (ovr_evt)          ovr_d = 1'b1;
    else if (overrun_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign noise_valid = valid_q;
  assign noise_data  = data_q;
  assign overrun     = ovr_q;

endmodule : noise_generator_mc

// File: tb/tb_noise_generator_mc.sv
// -----------------------------------------------------------------------------
// tb_noise_generator_mc
//   Directed bench for noise_generator_mc (WIDTH=16, NUM_CH=4, DIV_W=8).
//   A reference model predicts each frame as it is produced and pushes it on
//   exp_q; a negedge monitor pops and compares on every accepted transfer.
//   Hand-computed constants anchor the model: from 16'hACE1 the LFSR steps
//   to 16'h59C3, giving 16'h2CE1 at level 11 and 16'h0B38 for the first
//   smoothed sample from y=0.
// -----------------------------------------------------------------------------
module tb_noise_generator_mc;

  localparam int W  = 16;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam logic [W-1:0] TB_TAPS = 16'hB400;
  localparam logic [W-1:0] TB_SEED = 16'hACE1;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            reset;
  logic            enable = 1'b0;
  logic [DW-1:0]   rate_div = '0;
  logic [NC-1:0]   mode = '0;
  logic [2*NC-1:0] noise_level = '0;
  logic            seed_load = 1'b0;
  logic [1:0]      seed_ch = '0;
  logic [W-1:0]    seed_value = '0;
  logic            noise_ready = 1'b0;
  logic            overrun_clr = 1'b0;
  logic            noise_valid;
  logic [W*NC-1:0] noise_data;
  logic            overrun;

  always #5 clk = ~clk;

  noise_generator_mc #(.WIDTH(W), .NUM_CH(NC), .DIV_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rate_div    (rate_div),
    .mode        (mode),
    .noise_level (noise_level),
    .seed_load   (seed_load),
    .seed_ch     (seed_ch),
    .seed_value  (seed_value),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .noise_data  (noise_data),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and compare helper
  // ---------------------------------------------------------------------------
  logic [W*NC-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_lfsr[NC];
  logic [W-1:0] m_y[NC];
  int           m_cnt;
  logic         m_valid;
  logic         m_ovr;

  function automatic logic [W-1:0] f_step(input logic [W-1:0] v);
    logic fb = 1'b0;
    for (int i = 0; i < W; i++) if (TB_TAPS[i]) fb ^= v[i];
    return {v[W-2:0], fb};
  endfunction

  function automatic int f_x(input logic [W-1:0] nxt, input logic [1:0] lvl);
    int base = int'(nxt[W-2:0]);
    case (lvl)
      2'b01:   return base / 8;
      2'b10:   return base / 4;
      2'b11:   return base / 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      logic [W-1:0] s = TB_SEED;
      repeat (c) s = {s[W-2:0], s[W-1]};
      m_lfsr[c] = s;
      m_y[c]    = '0;
    end
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  // Effect of the coming posedge given the inputs currently driven.
  task automatic model_edge();
    logic            tk;
    logic            evt = 1'b0;
    logic [W*NC-1:0] frm;
    tk = enable && (m_cnt == int'(rate_div));
    if (!enable || tk) m_cnt = 0;
    else               m_cnt = (m_cnt + 1) % (1 << DW);
    for (int c = 0; c < NC; c++) begin
      logic [W-1:0] nxt = f_step(m_lfsr[c]);
      int xi = f_x(nxt, noise_level[2*c +: 2]);
      int d  = xi - int'(m_y[c]);
      int ds = d >>> 2;
      int yn = (int'(m_y[c]) + ds) & 32'hFFFF;
      frm[c*W +: W] = mode[c] ? yn[W-1:0] : xi[W-1:0];
      if (seed_load && (int'(seed_ch) == c)) begin
        m_lfsr[c] = (seed_value == '0) ? TB_SEED : seed_value;
        m_y[c]    = '0;
      end else if (tk) begin
        m_lfsr[c] = nxt;
        m_y[c]    = yn[W-1:0];
      end
    end
    if (tk) begin
      if (!m_valid || noise_ready) begin
        exp_q.push_back(frm);
        m_valid = 1'b1;
      end else begin
        evt = 1'b1;
      end
    end else if (m_valid && noise_ready) begin
      m_valid = 1'b0;
    end
    if (evt)              m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock, inputs settle 2 time units after the edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #2;
    check("valid", noise_valid, m_valid);
    check("overrun", overrun, m_ovr);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every accepted frame against the scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && noise_valid && noise_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame: got %h, expected no frame (t=%0t)", noise_data, $time);
      end else begin
        check("frame", noise_data, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W*NC-1:0] held;
    int              vc;

    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", noise_valid, 1'b0);
    check("rst_data", noise_data, '0);
    check("rst_overrun", overrun, 1'b0);

    // 1: first frame after reset, every-cycle ticks, level 11
    reset = 1'b0; enable = 1'b1; rate_div = 0; noise_level = 8'hFF; mode = '0;
    noise_ready = 1'b1;
    cyc();
    check("t1_ch0_first", noise_data[15:0], 16'h2CE1);
    repeat (6) cyc();

    // distinct levels per channel
    noise_level = 8'b11_10_01_00;
    repeat (4) cyc();

    // 2: rate_div=3 -> valid one cycle in four
    noise_level = 8'hFF; rate_div = 3;
    repeat (4) cyc();
    vc = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (noise_valid) vc++;
    end
    check("t2_valid_cycles", vc, 4);

    // enable low: no ticks, everything holds
    enable = 1'b0;
    repeat (5) cyc();

    // 3: back-pressure across two ticks -> data held, overrun set
    enable = 1'b1; rate_div = 0; noise_ready = 1'b0;
    cyc();
    held = noise_data;
    cyc();
    cyc();
    check("t3_data_held", noise_data, held);
    check("t3_overrun_set", overrun, 1'b1);
    overrun_clr = 1'b1;
    cyc();
    check("t3_clr_vs_event", overrun, 1'b1);
    overrun_clr = 1'b0;
    noise_ready = 1'b1;
    repeat (3) cyc();
    enable = 1'b0; overrun_clr = 1'b1;
    cyc();
    check("t3_clr", overrun, 1'b0);
    overrun_clr = 1'b0;

    // 4: seed ch2 with 0 on a tick; other channels keep stepping
    enable = 1'b1; rate_div = 0; noise_level = 8'hFF; mode = '0;
    repeat (3) cyc();
    seed_load = 1'b1; seed_ch = 2; seed_value = '0;
    cyc();
    seed_load = 1'b0;
    cyc();
    check("t4_ch2_reseed", noise_data[47:32], 16'h2CE1);
    // non-zero seed: 0001 steps to 0002, level 11 -> 0001
    seed_load = 1'b1; seed_ch = 1; seed_value = 16'h0001;
    cyc();
    seed_load = 1'b0;
    cyc();
    check("t4_ch1_seed1", noise_data[31:16], 16'h0001);

    // 5: smoothed channel from y=0: first sample is 2CE1>>>2
    enable = 1'b0; seed_load = 1'b1; seed_ch = 3; seed_value = '0; mode = 4'b1000;
    cyc();
    seed_load = 1'b0; enable = 1'b1;
    cyc();
    check("t5_ch3_smooth_first", noise_data[63:48], 16'h0B38);
    mode = 4'hF;
    repeat (20) cyc();
    mode = 4'b0101;
    repeat (6) cyc();

    // rate_div lowered below the running count -> wrap before next tick
    mode = '0; rate_div = 10;
    repeat (6) cyc();
    rate_div = 2;
    repeat (260) cyc();

    // 6: asynchronous reset mid-frame with valid and overrun set
    rate_div = 0; noise_ready = 1'b0;
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    check("t6_valid", noise_valid, 1'b0);
    check("t6_data", noise_data, '0);
    check("t6_overrun", overrun, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0; enable = 1'b1; rate_div = 0; noise_level = 8'hFF; mode = '0;
    noise_ready = 1'b1;
    cyc();
    check("t6_ch0_first", noise_data[15:0], 16'h2CE1);
    repeat (4) cyc();

    // drain
    enable = 1'b0;
    repeat (3) cyc();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_noise_generator_mc
